// File: rtl/poly_coeff_streamer_if.sv
// Host-load / multiplier-stream signal bundle for poly_coeff_streamer.
interface poly_coeff_streamer_if #(
  parameter int unsigned CW = 30
);
  logic          in_valid;
  logic          in_sel;
  logic [CW-1:0] in_data;
  logic          in_ready;
  logic          go;
  logic          busy;
  logic          start;
  logic [CW-1:0] a_out;
  logic [CW-1:0] b_out;
  logic          stream_valid;
  logic          stream_last;
  logic          done;

  modport master (
    output in_valid, in_sel, in_data, go,
    input  in_ready, busy, start, a_out, b_out, stream_valid, stream_last, done
  );

  modport slave (
    input  in_valid, in_sel, in_data, go,
    output in_ready, busy, start, a_out, b_out, stream_valid, stream_last, done
  );
endinterface

// File: rtl/poly_coeff_streamer.sv
// Buffers two N-coefficient polynomials from the host, then streams the pair
// to the multiplier one coefficient per cycle after a start pulse.
module poly_coeff_streamer #(
  parameter int unsigned N    = 1024,
  parameter int unsigned LOGN = 10,
  parameter int unsigned CW   = 30
) (
  input logic                   clk,
  input logic                   reset,
  poly_coeff_streamer_if.slave  bus
);
  localparam int unsigned PW = LOGN + 1;

  typedef enum logic [2:0] {LOAD, START, PREFETCH, STREAM, FINISH} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wa_q, wa_d, wb_q, wb_d;
  logic [LOGN-1:0] rd_ptr_q, rd_ptr_d, idx_q, idx_d;
  logic            start_d, valid_d, last_d, done_d, busy_d;
  logic            a_full, b_full, wr_a, wr_b;
  logic [CW-1:0]   rd_a, rd_b, a_d, b_d;
  logic [CW-1:0]   mem_a [N];
  logic [CW-1:0]   mem_b [N];

  assign a_full       = (wa_q == PW'(N));
  assign b_full       = (wb_q == PW'(N));
  assign bus.in_ready = (state_q == LOAD) && (bus.in_sel ? !b_full : !a_full);
  assign wr_a         = !reset && bus.in_valid && bus.in_ready && !bus.in_sel;
  assign wr_b         = !reset && bus.in_valid && bus.in_ready &&  bus.in_sel;

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_d  = state_q;
    wa_d     = wa_q;
    wb_d     = wb_q;
    rd_ptr_d = rd_ptr_q + LOGN'(1);
    idx_d    = idx_q;
    case (state_q)
      LOAD: begin
        rd_ptr_d = '0;
        if (wr_a) wa_d = wa_q + PW'(1);
        if (wr_b) wb_d = wb_q + PW'(1);
        if (bus.go && a_full && b_full) state_d = START;
      end
      START:    state_d = PREFETCH;
      PREFETCH: begin
        idx_d   = '0;
        state_d = STREAM;
      end
      STREAM: begin
        idx_d = idx_q + LOGN'(1);
        if (idx_q == LOGN'(N - 1)) state_d = FINISH;
      end
      FINISH: begin
        wa_d    = '0;
        wb_d    = '0;
        state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
    start_d = (state_d == START);
    valid_d = (state_d == STREAM);
    last_d  = (state_d == STREAM) && (idx_d == LOGN'(N - 1));
    done_d  = (state_d == FINISH);
    busy_d  = (state_d != LOAD);
    a_d     = valid_d ? rd_a : '0;
    b_d     = valid_d ? rd_b : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= LOAD;
      wa_q             <= '0;
      wb_q             <= '0;
      rd_ptr_q         <= '0;
      idx_q            <= '0;
      bus.start        <= 1'b0;
      bus.stream_valid <= 1'b0;
      bus.stream_last  <= 1'b0;
      bus.done         <= 1'b0;
      bus.busy         <= 1'b0;
      bus.a_out        <= '0;
      bus.b_out        <= '0;
    end else begin
      state_q          <= state_d;
      wa_q             <= wa_d;
      wb_q             <= wb_d;
      rd_ptr_q         <= rd_ptr_d;
      idx_q            <= idx_d;
      bus.start        <= start_d;
      bus.stream_valid <= valid_d;
      bus.stream_last  <= last_d;
      bus.done         <= done_d;
      bus.busy         <= busy_d;
      bus.a_out        <= a_d;
      bus.b_out        <= b_d;
    end
  end

  // Coefficient storage: write port from the host, one-cycle read toward the multiplier.
  always_ff @(posedge clk) begin
    if (wr_a) mem_a[wa_q[LOGN-1:0]] <= bus.in_data;
    if (wr_b) mem_b[wb_q[LOGN-1:0]] <= bus.in_data;
    rd_a <= mem_a[rd_ptr_q];
    rd_b <= mem_b[rd_ptr_q];
  end
endmodule

// File: tb/tb_poly_coeff_streamer.sv
// Directed bench for poly_coeff_streamer: a host model loads buffers, a
// scoreboard holds the expected stream and a negedge monitor compares it.
module tb_poly_coeff_streamer;
  localparam int unsigned N    = 1024;
  localparam int unsigned LOGN = 10;
  localparam int unsigned CW   = 30;

  typedef struct packed {
    logic [CW-1:0] a;
    logic [CW-1:0] b;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  poly_coeff_streamer_if #(.CW(CW)) bus ();

  poly_coeff_streamer #(.N(N), .LOGN(LOGN), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t          sb_q[$];
  logic [CW-1:0] m_a [N];
  logic [CW-1:0] m_b [N];
  int unsigned   m_wa, m_wb;
  bit            m_busy;
  int            checks, errors;
  int            popped, done_cnt, start_cnt, exp_starts;
  logic          prev_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stream monitor: pulses, done timing and scoreboard comparison.
  always @(negedge clk) begin
    exp_t e;
    if (bus.start) start_cnt++;
    if (bus.done)  done_cnt++;
    if (bus.start || bus.stream_valid || bus.done || bus.stream_last)
      check("pulse_excl",
            64'({$onehot({bus.start, bus.stream_valid, bus.done}), !bus.stream_last || bus.stream_valid}),
            64'(2'b11));
    if (prev_last || bus.done)
      check("done_after_last", 64'(bus.done), 64'(prev_last));
    if (bus.stream_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 64'(sb_q.size()), 64'(1));
      end else begin
        e = sb_q.pop_front();
        check("stream_word", 64'({bus.a_out, bus.b_out, bus.stream_last}), 64'(e));
        popped++;
      end
    end
    prev_last = bus.stream_last;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic write_word(input logic sel, input logic [CW-1:0] d);
    logic exp_rdy;
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_data  = d;
    #1;
    exp_rdy = !m_busy && (sel ? (m_wb < N) : (m_wa < N));
    check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    if (exp_rdy) begin
      if (sel) begin m_b[m_wb] = d; m_wb++; end
      else     begin m_a[m_wa] = d; m_wa++; end
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic load_random();
    for (int i = 0; i < int'(N); i++) begin
      write_word(1'b0, CW'($urandom));
      write_word(1'b1, CW'($urandom));
    end
  endtask

  task automatic pulse_go();
    exp_t e;
    bit   acc;
    acc = !m_busy && (m_wa == N) && (m_wb == N);
    if (acc) begin
      for (int i = 0; i < int'(N); i++) begin
        e.a = m_a[i]; e.b = m_b[i]; e.last = (i == int'(N) - 1);
        sb_q.push_back(e);
      end
      m_busy = 1'b1; m_wa = 0; m_wb = 0;
      exp_starts++;
    end
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    check("start", 64'(bus.start), 64'(acc));
    check("busy_after_go", 64'(bus.busy), 64'(acc));
  endtask

  // Wait for done; optionally keep writes and go asserted the whole time.
  task automatic wait_done(input bit hold);
    int d0, n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < int'(N) + 20) begin
      if (hold) begin
        bus.in_valid = 1'b1;
        bus.go       = 1'b1;
        bus.in_sel   = n[0];
        bus.in_data  = CW'($urandom);
        #1;
        check("ready_while_busy", 64'(bus.in_ready), 64'(0));
      end
      step();
      n++;
    end
    bus.in_valid = 1'b0;
    bus.go       = 1'b0;
    bus.in_sel   = 1'b0;
    check("done_seen", 64'(done_cnt - d0), 64'(1));
    check("sb_drained", 64'(sb_q.size()), 64'(0));
    check("start_count", 64'(start_cnt), 64'(exp_starts));
    m_busy = 1'b0;
    step();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_start"}, 64'(bus.start), 64'(0));
    check({tag, "_valid"}, 64'(bus.stream_valid), 64'(0));
    check({tag, "_last"},  64'(bus.stream_last), 64'(0));
    check({tag, "_done"},  64'(bus.done), 64'(0));
    check({tag, "_busy"},  64'(bus.busy), 64'(0));
    check({tag, "_a"},     64'(bus.a_out), 64'(0));
    check({tag, "_b"},     64'(bus.b_out), 64'(0));
    check({tag, "_ready"}, 64'(bus.in_ready), 64'(1));
  endtask

  initial begin
    int base, n, d0;
    bus.in_valid = 1'b0;
    bus.in_sel   = 1'b0;
    bus.in_data  = '0;
    bus.go       = 1'b0;
    reset        = 1'b1;
    prev_last    = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    check_idle("reset");

    // Interleaved ramp load and full transmission.
    for (int i = 0; i < int'(N); i++) begin
      write_word(1'b0, CW'(i));
      write_word(1'b1, CW'(int'(N) - 1 - i));
    end
    pulse_go();
    wait_done(1'b0);

    // One B word short: go ignored; full A refuses writes, B still accepts one.
    for (int i = 0; i < int'(N); i++)     write_word(1'b0, CW'($urandom));
    for (int i = 0; i < int'(N) - 1; i++) write_word(1'b1, CW'($urandom));
    pulse_go();
    repeat (3) begin
      step();
      check("short_busy", 64'(bus.busy), 64'(0));
      check("short_start", 64'(bus.start), 64'(0));
    end
    write_word(1'b0, CW'($urandom));
    write_word(1'b0, CW'($urandom));
    write_word(1'b1, CW'($urandom));
    pulse_go();
    wait_done(1'b1);

    // Reset in the middle of the stream, then reload from scratch.
    load_random();
    pulse_go();
    base = popped;
    n    = 0;
    while (popped < base + 501 && n < 600) begin
      step();
      n++;
    end
    check("reached_idx500", 64'(popped - base), 64'(501));
    reset = 1'b1;
    sb_q.delete();
    d0 = done_cnt;
    step();
    reset  = 1'b0;
    m_busy = 1'b0;
    m_wa   = 0;
    m_wb   = 0;
    check_idle("midreset");
    repeat (4) step();
    check("no_done_after_reset", 64'(done_cnt), 64'(d0));
    pulse_go();
    load_random();
    pulse_go();
    wait_done(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
